// File: rtl/id_stage.sv
// Instruction decode stage: RV32I field decode, immediate generation, register-file
// read with writeback bypass, load-use stall, and the registered ID/EX boundary.
module id_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  localparam int unsigned AW        = $clog2(REG_COUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           instr_i,
  input  logic [31:0]           pc_i,
  input  logic                  instr_valid_i,
  output logic                  stall_o,
  output logic                  rf_read_en_o,
  output logic [AW-1:0]         rf_read_addr1_o,
  output logic [AW-1:0]         rf_read_addr2_o,
  input  logic [DATA_WIDTH-1:0] rf_read_data1_i,
  input  logic [DATA_WIDTH-1:0] rf_read_data2_i,
  input  logic                  wb_en_i,
  input  logic [AW-1:0]         wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  flush_i,
  input  logic                  ex_ready_i,
  output logic                  ex_valid_o,
  output logic [31:0]           ex_pc_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [AW-1:0]         ex_rd_o,
  output logic [3:0]            ex_alu_op_o,
  output logic                  ex_alu_src_imm_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'h33,
    OPC_OP_IMM = 7'h13,
    OPC_LOAD   = 7'h03,
    OPC_STORE  = 7'h23,
    OPC_BRANCH = 7'h63,
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6F,
    OPC_JALR   = 7'h67
  } opcode_e;

  opcode_e               opcode;
  logic [2:0]            funct3;
  logic [AW-1:0]         rs1, rs2, rd;
  logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic [3:0]            d_alu_op;
  logic                  d_src_imm, d_wr, d_mr, d_mw, d_br, d_j;
  logic                  use_rs1, use_rs2, hazard;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data;

  assign opcode = opcode_e'(instr_i[6:0]);
  assign funct3 = instr_i[14:12];
  assign rs1    = AW'(instr_i[19:15]);
  assign rs2    = AW'(instr_i[24:20]);
  assign rd     = AW'(instr_i[11:7]);

  assign rf_read_addr1_o = rs1;
  assign rf_read_addr2_o = rs2;
  assign rf_read_en_o    = instr_valid_i;

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    imm32     = '0;
    d_alu_op  = '0;
    d_src_imm = 1'b0;
    d_wr      = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_br      = 1'b0;
    d_j       = 1'b0;
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    case (opcode)
      OPC_OP:     begin d_wr = 1'b1; d_alu_op = {instr_i[30], funct3}; use_rs2 = 1'b1; end
      OPC_OP_IMM: begin
        d_wr = 1'b1; d_src_imm = 1'b1; imm32 = imm_i;
        d_alu_op = {instr_i[30] & (funct3 == 3'b101), funct3};
      end
      OPC_LOAD:   begin d_wr = 1'b1; d_mr = 1'b1; d_src_imm = 1'b1; imm32 = imm_i; end
      OPC_STORE:  begin d_mw = 1'b1; d_src_imm = 1'b1; imm32 = imm_s; use_rs2 = 1'b1; end
      OPC_BRANCH: begin d_br = 1'b1; imm32 = imm_b; use_rs2 = 1'b1; end
      OPC_LUI, OPC_AUIPC: begin d_wr = 1'b1; d_src_imm = 1'b1; imm32 = imm_u; use_rs1 = 1'b0; end
      OPC_JAL:    begin d_wr = 1'b1; d_j = 1'b1; imm32 = imm_j; use_rs1 = 1'b0; end
      OPC_JALR:   begin d_wr = 1'b1; d_j = 1'b1; d_src_imm = 1'b1; imm32 = imm_i; end
      default: ;
    endcase
  end

  // Bypass only needs to match a non-zero source; index 0 already forces zero.
  always_comb begin
    rs1_data = rf_read_data1_i;
    rs2_data = rf_read_data2_i;
    if (rs1 == '0)                           rs1_data = '0;
    else if (wb_en_i && (wb_addr_i == rs1))  rs1_data = wb_data_i;
    if (rs2 == '0)                           rs2_data = '0;
    else if (wb_en_i && (wb_addr_i == rs2))  rs2_data = wb_data_i;
  end

  assign hazard = instr_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_o != '0) &
                  ((use_rs1 & (ex_rd_o == rs1)) | (use_rs2 & (ex_rd_o == rs2)));
  assign stall_o = hazard | ~ex_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o       <= 1'b0;
      ex_pc_o          <= '0;
      ex_rs1_data_o    <= '0;
      ex_rs2_data_o    <= '0;
      ex_imm_o         <= '0;
      ex_rd_o          <= '0;
      ex_alu_op_o      <= '0;
      ex_alu_src_imm_o <= 1'b0;
      ex_reg_write_o   <= 1'b0;
      ex_mem_read_o    <= 1'b0;
      ex_mem_write_o   <= 1'b0;
      ex_branch_o      <= 1'b0;
      ex_jump_o        <= 1'b0;
    end else if (flush_i || (ex_ready_i && hazard)) begin
      // Flush and load-use bubble both kill the slot; data fields are don't-care.
      ex_valid_o     <= 1'b0;
      ex_reg_write_o <= 1'b0;
      ex_mem_read_o  <= 1'b0;
      ex_mem_write_o <= 1'b0;
      ex_branch_o    <= 1'b0;
      ex_jump_o      <= 1'b0;
    end else if (ex_ready_i) begin
      ex_valid_o       <= instr_valid_i;
      ex_pc_o          <= pc_i;
      ex_rs1_data_o    <= rs1_data;
      ex_rs2_data_o    <= rs2_data;
      ex_imm_o         <= DATA_WIDTH'($signed(imm32));
      ex_rd_o          <= rd;
      ex_alu_op_o      <= d_alu_op;
      ex_alu_src_imm_o <= d_src_imm;
      ex_reg_write_o   <= instr_valid_i & d_wr & (rd != '0);
      ex_mem_read_o    <= instr_valid_i & d_mr;
      ex_mem_write_o   <= instr_valid_i & d_mw;
      ex_branch_o      <= instr_valid_i & d_br;
      ex_jump_o        <= instr_valid_i & d_j;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed decode/hazard/bypass/reset steps, then a random stream
// compared against an arithmetic reference model of the decode stage.
module tb_id_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i, pc_i;
  logic        instr_valid_i, stall_o, rf_read_en_o;
  logic [4:0]  rf_read_addr1_o, rf_read_addr2_o;
  logic [31:0] rf_read_data1_i, rf_read_data2_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        flush_i, ex_ready_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rd_o;
  logic [3:0]  ex_alu_op_o;
  logic        ex_alu_src_imm_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_jump_o;

  id_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i), .instr_valid_i(instr_valid_i),
    .stall_o(stall_o), .rf_read_en_o(rf_read_en_o), .rf_read_addr1_o(rf_read_addr1_o),
    .rf_read_addr2_o(rf_read_addr2_o), .rf_read_data1_i(rf_read_data1_i),
    .rf_read_data2_i(rf_read_data2_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_alu_src_imm_o(ex_alu_src_imm_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .ex_branch_o(ex_branch_o),
    .ex_jump_o(ex_jump_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    bit        valid;
    bit [31:0] pc, rs1d, rs2d, imm;
    bit [4:0]  rd;
    bit [3:0]  aluop;
    bit        src, wr, mr, mw, br, j;
  } ex_t;

  logic [143:0] dut_v;
  assign dut_v = {ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_o, ex_alu_op_o,
                  ex_alu_src_imm_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_jump_o};

  int          checks = 0;
  int          errors = 0;
  ex_t         m;
  ex_t         snap;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] sext(longint v, int bits);
    if (v >= (longint'(1) << (bits - 1))) v -= (longint'(1) << bits);
    return 32'(v);
  endfunction

  // Reference decode built from field arithmetic on the instruction word.
  function automatic ex_t decode(bit [31:0] w);
    ex_t    d = '0;
    longint u = w;
    int     op = int'(u % 128);
    int     f3 = int'((u >> 12) % 8);
    int     b30 = int'((u >> 30) % 2);
    longint immi = u >> 20;
    longint imms = ((u >> 25) << 5) + ((u >> 7) % 32);
    longint immb = ((u >> 31) << 12) + (((u >> 7) % 2) << 11) + (((u >> 25) % 64) << 5) + (((u >> 8) % 16) << 1);
    longint immj = ((u >> 31) << 20) + (((u >> 12) % 256) << 12) + (((u >> 20) % 2) << 11) + (((u >> 21) % 1024) << 1);
    d.rd = 5'((u >> 7) % 32);
    case (op)
      'h33: begin d.wr = 1; d.aluop = 4'(b30 * 8 + f3); end
      'h13: begin d.wr = 1; d.src = 1; d.imm = sext(immi, 12); d.aluop = 4'((f3 == 5 && b30 == 1) ? 8 + f3 : f3); end
      'h03: begin d.wr = 1; d.mr = 1; d.src = 1; d.imm = sext(immi, 12); end
      'h23: begin d.mw = 1; d.src = 1; d.imm = sext(imms, 12); end
      'h63: begin d.br = 1; d.imm = sext(immb, 13); end
      'h37, 'h17: begin d.wr = 1; d.src = 1; d.imm = 32'((u >> 12) << 12); end
      'h6F: begin d.wr = 1; d.j = 1; d.imm = sext(immj, 21); end
      'h67: begin d.wr = 1; d.j = 1; d.src = 1; d.imm = sext(immi, 12); end
      default: ;
    endcase
    if (d.rd == 0) d.wr = 0;
    return d;
  endfunction

  function automatic bit hazard(ex_t cur, bit [31:0] w, bit iv);
    int op = int'(w[6:0]);
    bit u1 = !(op == 'h37 || op == 'h17 || op == 'h6F);
    bit u2 = (op == 'h33 || op == 'h23 || op == 'h63);
    return iv && cur.valid && cur.mr && cur.rd != 0 &&
           ((u1 && cur.rd == w[19:15]) || (u2 && cur.rd == w[24:20]));
  endfunction

  function automatic ex_t kill(ex_t e);
    ex_t k = e;
    k.valid = 0; k.wr = 0; k.mr = 0; k.mw = 0; k.br = 0; k.j = 0;
    return k;
  endfunction

  function automatic bit [31:0] opnd(bit [4:0] idx, bit [31:0] rfd);
    if (idx == 0) return 32'h0;
    if (wb_en_i && wb_addr_i == idx) return wb_data_i;
    return rfd;
  endfunction

  task automatic set_in(input logic [31:0] ins, input logic iv);
    instr_i = ins; instr_valid_i = iv; pc_i = pc_ctr; pc_ctr += 4;
    rf_read_data1_i = $urandom; rf_read_data2_i = $urandom;
    wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0; flush_i = 0; ex_ready_i = 1;
  endtask

  task automatic cycle(input string tag);
    ex_t nx;
    bit  hz;
    #1;
    hz = hazard(m, instr_i, instr_valid_i);
    chk({tag, "/stall"}, 144'(stall_o), 144'(hz | !ex_ready_i));
    chk({tag, "/rf"}, 144'({rf_read_en_o, rf_read_addr1_o, rf_read_addr2_o}),
        144'({instr_valid_i, instr_i[19:15], instr_i[24:20]}));
    if (flush_i)          nx = kill(m);
    else if (!ex_ready_i) nx = m;
    else if (hz)          nx = kill(m);
    else begin
      nx       = decode(instr_i);
      nx.pc    = pc_i;
      nx.rs1d  = opnd(instr_i[19:15], rf_read_data1_i);
      nx.rs2d  = opnd(instr_i[24:20], rf_read_data2_i);
      nx.valid = instr_valid_i;
      if (!instr_valid_i) nx = kill(nx);
    end
    @(posedge clk_i); #1;
    m = nx;
    if (m.valid) chk({tag, "/ex"}, dut_v, m);
    else chk({tag, "/ex_idle"}, 144'({dut_v[143], dut_v[4:0]}), 144'({m.valid, m.wr, m.mr, m.mw, m.br, m.j}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int          ops[10] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h37, 'h17, 'h6F, 'h67, 'h0B};

    rst_i = 1;
    set_in(32'h0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_state", dut_v, '0);
    rst_i = 0;
    m = '0;

    set_in(32'h00500093, 1); cycle("addi5");
    chk("addi5_valid", 144'(ex_valid_o), 144'(1));
    chk("addi5_rd", 144'(ex_rd_o), 144'(1));
    chk("addi5_imm", 144'(ex_imm_o), 144'(5));
    chk("addi5_ctl", 144'({ex_reg_write_o, ex_alu_src_imm_o, ex_alu_op_o}), 144'(6'b11_0000));

    set_in(32'hFFF00093, 1); cycle("addim1");
    chk("addim1_imm", 144'(ex_imm_o), 144'(32'hFFFF_FFFF));
    set_in(32'h00500013, 1); cycle("addi_x0");
    chk("addi_x0_wr", 144'(ex_reg_write_o), 144'(0));

    set_in(32'h0000A103, 1); cycle("lw");
    set_in(32'h001101B3, 1);
    #1;
    chk("lu_stall", 144'(stall_o), 144'(1));
    cycle("lu_bubble");
    chk("lu_bubble_valid", 144'(ex_valid_o), 144'(0));
    cycle("lu_add");
    chk("lu_add_issue", 144'({ex_valid_o, ex_rd_o}), 144'({1'b1, 5'd3}));

    set_in(32'h000281B3, 1);
    wb_en_i = 1; wb_addr_i = 5; wb_data_i = 32'hDEADBEEF; rf_read_data1_i = 0;
    cycle("bypass");
    chk("bypass_rs1", 144'(ex_rs1_data_o), 144'(32'hDEADBEEF));
    chk("bypass_rs2", 144'(ex_rs2_data_o), 144'(0));

    snap = m;
    for (int i = 0; i < 3; i++) begin
      set_in(32'h00700113, 1); ex_ready_i = 0;
      #1;
      chk("hold_stall", 144'(stall_o), 144'(1));
      cycle("hold");
      chk("hold_regs", dut_v, snap);
    end
    set_in(32'h00700113, 1); ex_ready_i = 0; flush_i = 1;
    cycle("flush");
    chk("flush_valid", 144'(ex_valid_o), 144'(0));

    set_in(32'h00300193, 1); cycle("pre_rst");
    set_in(32'h00400213, 1);
    #3; rst_i = 1; #1;
    chk("async_rst", dut_v, '0);
    @(posedge clk_i); #1;
    rst_i = 0;
    m = '0;
    chk("rst_release", dut_v, '0);
    set_in(32'h0000007F, 1); cycle("unknown_op");
    chk("unknown_op_ctl", 144'({ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_jump_o}),
        144'(6'b10_0000));

    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      w[6:0]   = 7'(ops[$urandom_range(0, 9)]);
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      set_in(w, ($urandom % 8) != 0);
      flush_i    = ($urandom % 16) == 0;
      ex_ready_i = ($urandom % 6) != 0;
      wb_en_i    = $urandom % 2;
      wb_addr_i  = 5'($urandom_range(0, 3));
      wb_data_i  = $urandom;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
